// File: rtl/down_timer_pkg.sv
// Shared types for down_timer: the timer state enum and its 2-bit encodings.
package down_timer_pkg;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_RUN    = 2'b01;
   localparam logic [1:0] ST_PAUSED = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      RUN    = ST_RUN,
      PAUSED = ST_PAUSED
   } timer_state_e;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counting timer with start/pause/abort and a one-cycle expiry pulse.
// Define DOWN_TIMER_AUTORELOAD_EN for periodic operation (reload on expiry, stay in RUN).
module down_timer
   import down_timer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             expire
);

   timer_state_e     state;
   logic             load_fire;
   logic [WIDTH-1:0] start_count;

   assign load_ready  = (state == IDLE);
   assign busy        = (state != IDLE);
   assign load_fire   = load_valid && load_ready;
   // A start coinciding with a load sees the value being loaded.
   assign start_count = load_fire ? load_value : count;

`ifdef DOWN_TIMER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reload <= '0;
      end else if (load_fire && !abort) begin
         reload <= load_value;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         count  <= '0;
         expire <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch reads the pre-edge count/state.
         expire <= 1'b0;
         if (abort) begin
            state <= IDLE;
            count <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (load_fire) count <= load_value;
                  if (start) begin
                     if (start_count == '0) expire <= 1'b1;
                     else                   state  <= RUN;
                  end
               end
               RUN, PAUSED: begin
                  if (pause) begin
                     state <= PAUSED;
                  end else begin
                     state <= RUN;
                     if (count == WIDTH'(1)) begin
                        expire <= 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
                        count  <= reload;
`else
                        count  <= '0;
                        state  <= IDLE;
`endif
                     end else begin
                        count <= count - WIDTH'(1);
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  count <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer; a scoreboard queue holds the cycle each expire pulse is due.
module tb_down_timer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             load_valid = 1'b0;
   logic             load_ready;
   logic [WIDTH-1:0] load_value = '0;
   logic             start = 1'b0;
   logic             pause = 1'b0;
   logic             abort = 1'b0;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             expire;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int sb[$];

   down_timer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_ready(load_ready), .load_value(load_value),
      .start(start), .pause(pause), .abort(abort),
      .count(count), .busy(busy), .expire(expire)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expire due in the cycle after edge (next edge + lat).
   task automatic expect_expire(input int lat);
      sb.push_back(cyc + 1 + lat);
   endtask

   task automatic load(input int v);
      load_valid = 1'b1;
      load_value = WIDTH'(v);
      step();
      load_valid = 1'b0;
   endtask

   // Scoreboard: every expire must match the queue head; a head that has passed is a miss.
   always @(negedge clk) begin
      if (sb.size() != 0 && sb[0] < cyc) begin
         check("expire_missed", cyc, sb[0]);
         void'(sb.pop_front());
      end
      if (expire) begin
         if (sb.size() != 0) begin
            check("expire_cycle", cyc, sb[0]);
            void'(sb.pop_front());
         end else begin
            check("expire_spurious", 1, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", load_ready, 1);
      check("rst_expire", expire, 0);
      rst_n = 1'b1;
      step();

`ifndef DOWN_TIMER_AUTORELOAD_EN
      // Load 5, start two cycles later, count to zero.
      load(5);
      check("load5_count", count, 5);
      step();
      start = 1'b1;
      expect_expire(5);
      step();
      start = 1'b0;
      check("run5_count0", count, 5);
      check("run5_busy", busy, 1);
      for (int k = 1; k <= 5; k++) begin
         step();
         check("run5_count", count, 5 - k);
      end
      check("run5_expire", expire, 1);
      check("run5_busy_end", busy, 0);
      check("run5_ready_at_expire", load_ready, 1);
      step();
      check("run5_expire_gone", expire, 0);

      // Load 6, pause for 3 cycles after 2 decrements.
      load(6);
      start = 1'b1;
      expect_expire(9);
      step();
      start = 1'b0;
      step(2);
      check("pause_pre", count, 4);
      pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("pause_hold", count, 4);
         check("pause_busy", busy, 1);
      end
      pause = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("pause_resume", count, 4 - k);
      end
      check("pause_expire", expire, 1);
      step();

      // Zero start: immediate expire, never busy.
      load(0);
      start = 1'b1;
      expect_expire(0);
      step();
      start = 1'b0;
      check("zero_busy", busy, 0);
      check("zero_expire", expire, 1);
      step();

      // Abort at count 7, then a start with count 0.
      load(10);
      start = 1'b1;
      step();
      start = 1'b0;
      step(3);
      check("abort_pre", count, 7);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_count", count, 0);
      check("abort_busy", busy, 0);
      check("abort_expire", expire, 0);
      start = 1'b1;
      expect_expire(0);
      step();
      start = 1'b0;
      check("abort_restart_expire", expire, 1);
      check("abort_restart_busy", busy, 0);
      step();

      // Load and start together; a load attempt while busy is refused.
      load_valid = 1'b1;
      load_value = WIDTH'(3);
      start = 1'b1;
      expect_expire(3);
      step();
      start = 1'b0;
      load_value = WIDTH'(9);
      check("ls_count", count, 3);
      check("ls_busy_ready", load_ready, 0);
      step();
      load_valid = 1'b0;
      check("ls_no_load", count, 2);
      step(2);
      check("ls_end", count, 0);
      check("ls_expire", expire, 1);

      // Back-to-back load+start in the expire cycle, then abort on the terminal decrement.
      load_valid = 1'b1;
      load_value = WIDTH'(2);
      start = 1'b1;
      step();
      load_valid = 1'b0;
      start = 1'b0;
      check("b2b_count", count, 2);
      check("b2b_busy", busy, 1);
      step();
      check("term_pre", count, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("term_abort_expire", expire, 0);
      check("term_abort_count", count, 0);
      step(2);
`else
      // Periodic tick: count 4,3,2,1,4,... with expire on each reload.
      load(4);
      start = 1'b1;
      expect_expire(4);
      expect_expire(8);
      step();
      start = 1'b0;
      check("ar_count0", count, 4);
      for (int k = 1; k <= 8; k++) begin
         step();
         check("ar_count", count, 4 - ((k - 1) % 4 + 1) + ((k % 4 == 0) ? 4 : 0));
         check("ar_ready", load_ready, 0);
      end
      check("ar_expire", expire, 1);
      step(2);
      check("ar_mid", count, 2);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("ar_abort_busy", busy, 0);
      check("ar_abort_count", count, 0);

      // Reload of 1: expire every cycle.
      load(1);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         expect_expire(0);
         step();
         check("ar1_expire", expire, 1);
         check("ar1_count", count, 1);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
`endif

      // Asynchronous reset mid-run.
      load(4);
      start = 1'b1;
      step();
      start = 1'b0;
      step(2);
      check("rstmid_pre", count, 2);
      rst_n = 1'b0;
      #1;
      check("rstmid_count", count, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_expire", expire, 0);
      step(2);
      rst_n = 1'b1;
      step(6);
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer with start/pause/abort control and a one-cycle expiry pulse. It is the consuming counterpart of the free-running up-counter: software or an FSM loads a cycle count and starts it, and the block counts to zero and signals expiry. It sits beside control FSMs that need timeouts, delays or periodic ticks.

## Interface
- WIDTH, 8, bit width of the count and load value
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- load_valid  input  1  load request; qualifies load_value
- load_ready  output  1  high when a load can be accepted (state IDLE)
- load_value  input  WIDTH  value transferred into count and the reload register on a load handshake
- start  input  1  single-cycle request to begin counting (honoured only in IDLE)
- pause  input  1  level; freezes the count while high during a run
- abort  input  1  single-cycle; cancels any run
- count  output  WIDTH  current remaining count
- busy  output  1  high in RUN or PAUSED
- expire  output  1  registered one-cycle pulse when the count reaches zero

## Operation
- States: IDLE, RUN, PAUSED. Reset: state IDLE, count 0, reload register 0, expire 0, busy 0, load_ready 1.
- load_ready = (state == IDLE); busy = (state != IDLE); both decoded from state.
- Load handshake (load_valid && load_ready): count <= load_value, reload <= load_value.
- Load and start in the same cycle: the load happens and start sees load_value as the start count.
- IDLE + start, start count != 0: go to RUN; count unchanged on that edge.
- IDLE + start, start count == 0: stay IDLE, expire = 1 for the following cycle.
- start outside IDLE is ignored. A load is never accepted outside IDLE.
- RUN, pause low: count decrements by 1 each cycle.
- RUN, pause high: go to PAUSED and hold count. PAUSED, pause low: return to RUN; the decrement resumes on the next edge.
- Terminal decrement, RUN with count == 1 and pause low: expire <= 1; without auto-reload, count <= 0 and state <= IDLE.
- Priority, highest first: abort, then pause, then decrement. abort in any state: state IDLE, count 0, expire 0, reload register retained.
- abort in the same cycle as the terminal decrement suppresses expire.
- Arithmetic is unsigned modulo 2^WIDTH. There is no underflow, because RUN is never entered or kept with count 0.

## Timing
- Start sampled at edge E0 with count L: count is L−k after edge E0+k, and expire is high for exactly the one cycle after edge E0+L.
- Expiry latency is L cycles after the start edge, plus one cycle per cycle that pause is high.
- busy rises the cycle after the start edge and falls together with the expire pulse (no auto-reload).
- load_ready returns in the cycle expire is high, so a back-to-back load plus start there is legal.
- rst_n assertion mid-run immediately forces all reset values, with no expire; deassertion is synchronised externally.

## Configuration
- DOWN_TIMER_AUTORELOAD_EN defined: the terminal decrement sets count <= reload, pulses expire and stays in RUN. This gives a periodic tick every reload cycles until abort.
  - With reload == 1, expire is high every cycle.
  - While running, load_ready stays 0.
- DOWN_TIMER_AUTORELOAD_EN undefined: one-shot behaviour as above, and the reload register may be optimised away.

## Structure
- Package down_timer_pkg holds the state enum typedef (timer_state_e: IDLE, RUN, PAUSED) and its 2-bit encoding constants.
- Single module; the datapath is one counter plus the reload register, so no sub-module is warranted.

## Test plan
- Reset, then load 5 and start 2 cycles later → count 5,4,3,2,1,0 on successive edges; expire high one cycle, 5 cycles after the start edge; busy low afterwards.
- Load 6, start, pause high for 3 cycles after 2 decrements → count holds at 4 for 3 cycles; expire 9 cycles after start.
- Load 0, then start → no RUN; expire pulses the next cycle; busy stays 0.
- Load 10, start, abort when count is 7 → count 0, IDLE, no expire; a later start with count 0 gives an immediate expire.
- Load and start in the same cycle with value 3 → expire 3 cycles later; load_valid while busy → load_ready 0 and count unaffected.
- Auto-reload build, load 4, start → expire every 4 cycles with count cycling 3,2,1,4; rst_n low mid-run → count 0, busy 0, expire 0 immediately.
